// File: rtl/lsu_stage_if.sv
// rtl/lsu_stage_if.sv - data memory bus between lsu_stage and the memory system
//
// Purpose: groups the req/gnt/rvalid data bus into one interface.
// Signals:
//   req    master->slave  request, held until gnt
//   we     master->slave  1 = store
//   addr   master->slave  word-aligned byte address
//   be     master->slave  byte enables, one bit per lane
//   wdata  master->slave  lane-replicated store data
//   gnt    slave->master  request accepted this cycle
//   rvalid slave->master  load data valid
//   rdata  slave->master  full-word read data
interface lsu_stage_if #(
   parameter int XLEN = 32
);
   logic                  req;
   logic                  we;
   logic [XLEN-1:0]       addr;
   logic [XLEN/8-1:0]     be;
   logic [XLEN-1:0]       wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [XLEN-1:0]       rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - memory-access pipeline stage between execute and writeback
//
// Purpose: accepts one instruction at a time from execute. Non-memory
// instructions retire one cycle later. Loads and stores go out on the
// req/gnt/rvalid bus with byte enables and lane steering, and load data is
// sign- or zero-extended by funct3. in_ready is low while a bus access is in
// flight, which stalls execute.
// Configuration macro: MISALIGN_TRAP_EN. When it is defined, a misaligned
// access makes no bus request and retires at once with wb_misalign=1. When it
// is undefined, byte enables that fall past the word boundary are dropped.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   in_valid / in_ready      handshake from execute
//   in_mem_read/in_mem_write load / store select
//   in_rf_write, in_rd_index destination write enable and index
//   in_inst, in_inst_addr    instruction word (funct3 = [14:12]) and its PC
//   in_alu_result            result for non-memory instructions
//   in_mem_addr, in_rs2      effective byte address and store data
//   dmem                     data bus (lsu_stage_if master)
//   wb_*                     registered writeback outputs; wb_valid pulses once per retire
module lsu_stage #(
   parameter int          XLEN     = 32,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mem_read,
   input  logic             in_mem_write,
   input  logic             in_rf_write,
   input  logic [4:0]       in_rd_index,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_inst_addr,
   input  logic [XLEN-1:0]  in_alu_result,
   input  logic [XLEN-1:0]  in_mem_addr,
   input  logic [XLEN-1:0]  in_rs2,
   lsu_stage_if.master      dmem,
   output logic             wb_valid,
   output logic [31:0]      wb_inst,
   output logic [XLEN-1:0]  wb_inst_addr,
   output logic [4:0]       wb_rd_index,
   output logic [XLEN-1:0]  wb_rd_content,
   output logic             wb_rf_write,
   output logic             wb_misalign
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;

   logic [1:0]       state;
   logic             op_we;
   logic             op_rf_write;
   logic [2:0]       op_funct3;
   logic [OFFW-1:0]  op_off;
   logic [4:0]       op_rd;
   logic [31:0]      op_inst;
   logic [XLEN-1:0]  op_pc;

   logic             accept;
   logic             is_mem;
   logic [2:0]       in_funct3;
   logic [OFFW-1:0]  in_off;
   logic [NB-1:0]    be_base;
   logic [NB-1:0]    be_in;
   logic [XLEN-1:0]  wdata_in;
   logic             misaligned;
   logic [XLEN-1:0]  shifted;
   logic [XLEN-1:0]  load_result;

   assign in_ready  = (state == IDLE);
   assign accept    = in_valid & in_ready;
   assign is_mem    = in_mem_read | in_mem_write;
   assign in_funct3 = in_inst[14:12];
   assign in_off    = in_mem_addr[OFFW-1:0];

   // Access size comes from funct3[1:0]; funct3[2] (unsigned) is only
   // meaningful for loads, so stores with it set get no byte enables.
   always_comb begin
      be_base = '0;
      case (in_funct3[1:0])
         2'b00:   be_base = NB'(1);
         2'b01:   be_base = NB'(3);
         2'b10:   be_base = NB'(4'hF);
         default: be_base = (XLEN == 64) ? '1 : '0;
      endcase
      if (in_mem_write && in_funct3[2])
         be_base = '0;
   end

   // Shifting inside NB bits drops any enables past the word boundary.
   assign be_in = be_base << in_off;

   always_comb begin
      wdata_in = in_rs2;
      case (in_funct3[1:0])
         2'b00:   wdata_in = {NB{in_rs2[7:0]}};
         2'b01:   wdata_in = {(NB/2){in_rs2[15:0]}};
         2'b10:   wdata_in = {(XLEN/32){in_rs2[31:0]}};
         default: wdata_in = in_rs2;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic [2:0] size_mask;
   always_comb begin
      case (in_funct3[1:0])
         2'b00:   size_mask = 3'd0;
         2'b01:   size_mask = 3'd1;
         2'b10:   size_mask = 3'd3;
         default: size_mask = 3'd7;
      endcase
   end
   assign misaligned = is_mem && ((in_mem_addr[2:0] & size_mask) != 3'd0);
`else
   assign misaligned = 1'b0;
`endif

   assign shifted = dmem.rdata >> {op_off, 3'b000};

   always_comb begin
      load_result = '0;
      case (op_funct3)
         3'b000:  load_result = XLEN'($signed(shifted[7:0]));
         3'b001:  load_result = XLEN'($signed(shifted[15:0]));
         3'b010:  load_result = XLEN'($signed(shifted[31:0]));
         3'b011:  load_result = (XLEN == 64) ? shifted : '0;
         3'b100:  load_result = XLEN'(shifted[7:0]);
         3'b101:  load_result = XLEN'(shifted[15:0]);
         3'b110:  load_result = (XLEN == 64) ? XLEN'(shifted[31:0]) : '0;
         default: load_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         dmem.req      <= 1'b0;
         dmem.we       <= 1'b0;
         dmem.addr     <= '0;
         dmem.be       <= '0;
         dmem.wdata    <= '0;
         wb_valid      <= 1'b0;
         wb_inst       <= NOP_INST;
         wb_inst_addr  <= '0;
         wb_rd_index   <= '0;
         wb_rd_content <= '0;
         wb_rf_write   <= 1'b0;
         wb_misalign   <= 1'b0;
         op_we         <= 1'b0;
         op_rf_write   <= 1'b0;
         op_funct3     <= '0;
         op_off        <= '0;
         op_rd         <= '0;
         op_inst       <= NOP_INST;
         op_pc         <= '0;
      end else begin
         // Bubble unless a retire below overrides these.
         wb_valid    <= 1'b0;
         wb_rf_write <= 1'b0;
         wb_inst     <= NOP_INST;
         wb_misalign <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (misaligned) begin
                     wb_valid      <= 1'b1;
                     wb_misalign   <= 1'b1;
                     wb_inst       <= in_inst;
                     wb_inst_addr  <= in_inst_addr;
                     wb_rd_index   <= in_rd_index;
                     wb_rd_content <= '0;
                  end else if (is_mem) begin
                     op_we       <= in_mem_write;
                     op_rf_write <= in_rf_write;
                     op_funct3   <= in_funct3;
                     op_off      <= in_off;
                     op_rd       <= in_rd_index;
                     op_inst     <= in_inst;
                     op_pc       <= in_inst_addr;
                     dmem.req    <= 1'b1;
                     dmem.we     <= in_mem_write;
                     dmem.addr   <= {in_mem_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                     dmem.be     <= be_in;
                     dmem.wdata  <= wdata_in;
                     state       <= REQ;
                  end else begin
                     wb_valid      <= 1'b1;
                     wb_inst       <= in_inst;
                     wb_inst_addr  <= in_inst_addr;
                     wb_rd_index   <= in_rd_index;
                     wb_rd_content <= in_alu_result;
                     wb_rf_write   <= in_rf_write;
                  end
               end
            end
            REQ: begin
               if (dmem.gnt) begin
                  dmem.req <= 1'b0;
                  if (op_we) begin
                     wb_valid      <= 1'b1;
                     wb_inst       <= op_inst;
                     wb_inst_addr  <= op_pc;
                     wb_rd_index   <= op_rd;
                     wb_rd_content <= '0;
                     state         <= IDLE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (dmem.rvalid) begin
                  wb_valid      <= 1'b1;
                  wb_inst       <= op_inst;
                  wb_inst_addr  <= op_pc;
                  wb_rd_index   <= op_rd;
                  wb_rd_content <= load_result;
                  wb_rf_write   <= op_rf_write;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_stage.sv
// tb/tb_lsu_stage.sv - directed self-checking bench for lsu_stage (XLEN=32)
module tb_lsu_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_mem_read = 1'b0;
   logic        in_mem_write = 1'b0;
   logic        in_rf_write = 1'b0;
   logic [4:0]  in_rd_index = '0;
   logic [31:0] in_inst = 32'h0;
   logic [31:0] in_inst_addr = '0;
   logic [31:0] in_alu_result = '0;
   logic [31:0] in_mem_addr = '0;
   logic [31:0] in_rs2 = '0;
   logic        wb_valid;
   logic [31:0] wb_inst;
   logic [31:0] wb_inst_addr;
   logic [4:0]  wb_rd_index;
   logic [31:0] wb_rd_content;
   logic        wb_rf_write;
   logic        wb_misalign;

   int total = 0;
   int bad = 0;

   lsu_stage_if #(.XLEN(32)) dmem_bus ();

   lsu_stage #(.XLEN(32), .NOP_INST(32'h00000013)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .in_rf_write(in_rf_write), .in_rd_index(in_rd_index),
      .in_inst(in_inst), .in_inst_addr(in_inst_addr),
      .in_alu_result(in_alu_result), .in_mem_addr(in_mem_addr), .in_rs2(in_rs2),
      .dmem(dmem_bus),
      .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_inst_addr(wb_inst_addr),
      .wb_rd_index(wb_rd_index), .wb_rd_content(wb_rd_content),
      .wb_rf_write(wb_rf_write), .wb_misalign(wb_misalign)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0; in_rf_write = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dmem_bus.gnt = 1'b0; dmem_bus.rvalid = 1'b0; dmem_bus.rdata = '0;
      step(); step();
      rst = 1'b0;
      total++; if (wb_inst !== 32'h13) begin bad++; $display("FAIL reset_wb_inst got %h want 00000013", wb_inst); end
      total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
      total++; if (dmem_bus.req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", dmem_bus.req); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_alu();
      in_valid = 1'b1; in_rf_write = 1'b1; in_rd_index = 5'd5;
      in_alu_result = 32'h1234; in_inst = 32'h00500293; in_inst_addr = 32'h100;
      step();
      idle_inputs();
      total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu_valid got %b want 1", wb_valid); end
      total++; if (wb_rd_content !== 32'h1234) begin bad++; $display("FAIL alu_content got %h want 00001234", wb_rd_content); end
      total++; if (wb_rd_index !== 5'd5) begin bad++; $display("FAIL alu_rd got %0d want 5", wb_rd_index); end
      total++; if (wb_inst_addr !== 32'h100) begin bad++; $display("FAIL alu_pc got %h want 00000100", wb_inst_addr); end
      step();
      total++; if (wb_valid !== 1'b0 || wb_inst !== 32'h13) begin bad++; $display("FAIL alu_bubble got valid=%b inst=%h want 0/00000013", wb_valid, wb_inst); end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_rf_write = 1'b1; in_rd_index = 5'd1; in_alu_result = 32'hA1;
      step();
      total++; if (wb_valid !== 1'b1 || wb_rd_content !== 32'hA1) begin bad++; $display("FAIL b2b_first got valid=%b data=%h want 1/000000a1", wb_valid, wb_rd_content); end
      in_rd_index = 5'd2; in_alu_result = 32'hB2; in_rf_write = 1'b0;
      step();
      idle_inputs();
      total++; if (wb_valid !== 1'b1 || wb_rd_content !== 32'hB2 || wb_rd_index !== 5'd2 || wb_rf_write !== 1'b0)
         begin bad++; $display("FAIL b2b_second got valid=%b data=%h rd=%0d rfw=%b want 1/000000b2/2/0", wb_valid, wb_rd_content, wb_rd_index, wb_rf_write); end
      step();
   endtask

   // Load with funct3 f3, gnt after gdly idle cycles, rvalid rdly cycles after gnt.
   task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input int gdly, input int rdly, input logic [31:0] exp);
      logic ready_ok;
      ready_ok = 1'b1;
      in_valid = 1'b1; in_mem_read = 1'b1; in_rf_write = 1'b1; in_rd_index = 5'd7;
      in_inst = {17'd0, f3, 5'd7, 7'h03}; in_mem_addr = addr; in_inst_addr = 32'h200;
      step();
      idle_inputs();
      total++; if (dmem_bus.req !== 1'b1 || dmem_bus.we !== 1'b0 || dmem_bus.addr !== {addr[31:2], 2'b00})
         begin bad++; $display("FAIL %s_req got req=%b we=%b addr=%h want 1/0/%h", name, dmem_bus.req, dmem_bus.we, dmem_bus.addr, {addr[31:2], 2'b00}); end
      for (int i = 0; i < gdly; i++) begin
         if (in_ready !== 1'b0 || dmem_bus.req !== 1'b1) ready_ok = 1'b0;
         step();
      end
      dmem_bus.gnt = 1'b1;
      step();
      dmem_bus.gnt = 1'b0;
      total++; if (dmem_bus.req !== 1'b0) begin bad++; $display("FAIL %s_req_drop got %b want 0", name, dmem_bus.req); end
      for (int i = 0; i < rdly - 1; i++) begin
         if (in_ready !== 1'b0 || wb_valid !== 1'b0) ready_ok = 1'b0;
         step();
      end
      if (in_ready !== 1'b0) ready_ok = 1'b0;
      dmem_bus.rvalid = 1'b1; dmem_bus.rdata = rdata;
      step();
      dmem_bus.rvalid = 1'b0; dmem_bus.rdata = 32'hDEAD0000;
      total++; if (ready_ok !== 1'b1) begin bad++; $display("FAIL %s_stall got %b want 1", name, ready_ok); end
      total++; if (wb_valid !== 1'b1 || wb_rd_content !== exp || wb_rf_write !== 1'b1 || wb_rd_index !== 5'd7)
         begin bad++; $display("FAIL %s_result got valid=%b data=%h rfw=%b rd=%0d want 1/%h/1/7", name, wb_valid, wb_rd_content, wb_rf_write, wb_rd_index, exp); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got %b want 1", name, in_ready); end
      step();
   endtask

   task automatic test_loads();
      do_load("lb",  3'b000, 32'h3, 32'h80FF0000, 2, 3, 32'hFFFFFF80);
      do_load("lhu", 3'b101, 32'h2, 32'h9ABC0000, 0, 1, 32'h00009ABC);
      do_load("lh",  3'b001, 32'h2, 32'h9ABC0000, 1, 2, 32'hFFFF9ABC);
      do_load("lw",  3'b010, 32'h40, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF);
      do_load("lbu", 3'b100, 32'h1, 32'h0000A500, 0, 1, 32'h000000A5);
   endtask

   task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      in_valid = 1'b1; in_mem_write = 1'b1; in_rf_write = 1'b1; in_rd_index = 5'd9;
      in_inst = {17'd0, f3, 5'd0, 7'h23}; in_mem_addr = addr; in_rs2 = rs2;
      step();
      idle_inputs();
      step();
      total++; if (dmem_bus.req !== 1'b1 || dmem_bus.we !== 1'b1 || dmem_bus.be !== exp_be ||
                   dmem_bus.wdata !== exp_wdata || dmem_bus.addr !== {addr[31:2], 2'b00})
         begin bad++; $display("FAIL %s_bus got req=%b we=%b be=%b wdata=%h addr=%h want 1/1/%b/%h/%h", name,
               dmem_bus.req, dmem_bus.we, dmem_bus.be, dmem_bus.wdata, dmem_bus.addr, exp_be, exp_wdata, {addr[31:2], 2'b00}); end
      dmem_bus.gnt = 1'b1;
      step();
      dmem_bus.gnt = 1'b0;
      total++; if (wb_valid !== 1'b1 || wb_rf_write !== 1'b0 || dmem_bus.req !== 1'b0 || in_ready !== 1'b1)
         begin bad++; $display("FAIL %s_retire got valid=%b rfw=%b req=%b rdy=%b want 1/0/0/1", name, wb_valid, wb_rf_write, dmem_bus.req, in_ready); end
      step();
   endtask

   task automatic test_stores();
      do_store("sh", 3'b001, 32'h2, 32'hAAAA5678, 4'b1100, 32'h56785678);
      do_store("sb", 3'b000, 32'h101, 32'h000000C3, 4'b0010, 32'hC3C3C3C3);
      do_store("sw", 3'b010, 32'h8, 32'h11223344, 4'b1111, 32'h11223344);
      do_store("sbad", 3'b100, 32'h0, 32'h11223344, 4'b0000, 32'h44444444);
`ifndef MISALIGN_TRAP_EN
      do_store("sw_mis", 3'b010, 32'h2, 32'h11223344, 4'b1100, 32'h11223344);
`endif
   endtask

   task automatic test_reset_mid();
      logic saw_valid;
      saw_valid = 1'b0;
      in_valid = 1'b1; in_mem_read = 1'b1; in_rf_write = 1'b1; in_rd_index = 5'd3;
      in_inst = {17'd0, 3'b010, 5'd3, 7'h03}; in_mem_addr = 32'h10;
      step();
      idle_inputs();
      dmem_bus.gnt = 1'b1;
      step();
      dmem_bus.gnt = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      if (wb_valid !== 1'b0) saw_valid = 1'b1;
      total++; if (in_ready !== 1'b1 || dmem_bus.req !== 1'b0) begin bad++; $display("FAIL rstmid_idle got rdy=%b req=%b want 1/0", in_ready, dmem_bus.req); end
      dmem_bus.rvalid = 1'b1; dmem_bus.rdata = 32'h55555555;
      step();
      dmem_bus.rvalid = 1'b0;
      if (wb_valid !== 1'b0) saw_valid = 1'b1;
      step();
      if (wb_valid !== 1'b0) saw_valid = 1'b1;
      total++; if (saw_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_wb got %b want 0", saw_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_state got rdy=%b want 1", in_ready); end
   endtask

   task automatic test_stray_gnt();
      dmem_bus.gnt = 1'b1;
      step();
      dmem_bus.gnt = 1'b0;
      total++; if (wb_valid !== 1'b0 || in_ready !== 1'b1 || dmem_bus.req !== 1'b0)
         begin bad++; $display("FAIL stray_gnt got valid=%b rdy=%b req=%b want 0/1/0", wb_valid, in_ready, dmem_bus.req); end
   endtask

`ifdef MISALIGN_TRAP_EN
   task automatic test_misalign();
      in_valid = 1'b1; in_mem_read = 1'b1; in_rf_write = 1'b1; in_rd_index = 5'd4;
      in_inst = {17'd0, 3'b010, 5'd4, 7'h03}; in_mem_addr = 32'h1;
      step();
      idle_inputs();
      total++; if (dmem_bus.req !== 1'b0) begin bad++; $display("FAIL mis_req got %b want 0", dmem_bus.req); end
      total++; if (wb_valid !== 1'b1 || wb_misalign !== 1'b1 || wb_rf_write !== 1'b0 || in_ready !== 1'b1)
         begin bad++; $display("FAIL mis_retire got valid=%b mis=%b rfw=%b rdy=%b want 1/1/0/1", wb_valid, wb_misalign, wb_rf_write, in_ready); end
      step();
      total++; if (wb_misalign !== 1'b0 || dmem_bus.req !== 1'b0) begin bad++; $display("FAIL mis_after got mis=%b req=%b want 0/0", wb_misalign, dmem_bus.req); end
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_loads();
      test_stores();
      test_reset_mid();
      test_stray_gnt();
`ifdef MISALIGN_TRAP_EN
      test_misalign();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
